// File: rtl/seg_display_if.sv
// Segment write path between the memory/IO stage (master) and the display controller (slave).
// busy flows back to the master while a decimal conversion is in flight.
interface seg_display_if;
  logic        seg_we;
  logic [31:0] wdata;
  logic        dec_mode;
  logic        busy;

  modport master (
    output seg_we,
    output wdata,
    output dec_mode,
    input  busy
  );

  modport slave (
    input  seg_we,
    input  wdata,
    input  dec_mode,
    output busy
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// Eight-digit seven-segment controller: hex or signed-decimal display of a 32-bit value,
// with a sequential double-dabble converter and a time-multiplexed digit scan.
module seg_display_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_display_if.slave bus,
  output logic [7:0]   seg_en,
  output logic [7:0]   seg_out
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [7:0] GlyphDash  = 8'hBF;
  localparam logic [7:0] GlyphBlank = 8'hFF;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} state_e;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    unique case (d)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              sign_q, sign_d;
  logic [31:0]       mag_q, mag_d;
  logic [39:0]       bcd_q, bcd_d;
  logic [4:0]        iter_q, iter_d;
  logic [7:0][7:0]   disp_q, disp_d;
  logic              busy_q, busy_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        seg_en_q, seg_en_d;
  logic [7:0]        seg_out_q, seg_out_d;

  logic [39:0]       bcd_adj;
  logic [7:0][7:0]   dec_disp;
  logic [7:0][7:0]   hex_disp;
  logic              overflow;
  logic [2:0]        msd;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 10; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
  end

  // Negatives lose one digit position to the '-' sign.
  always_comb begin
    overflow = sign_q ? (bcd_q[39:28] != '0) : (bcd_q[39:32] != '0);
    msd      = '0;
    for (int i = 1; i < 8; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    dec_disp = '0;
    for (int i = 0; i < 8; i++) begin
      if (overflow)                          dec_disp[i] = GlyphDash;
      else if (i <= int'(msd))               dec_disp[i] = glyph(bcd_q[4*i +: 4]);
      else if (sign_q && i == int'(msd) + 1) dec_disp[i] = GlyphDash;
      else                                   dec_disp[i] = GlyphBlank;
    end
  end

  always_comb begin
    hex_disp = '0;
    for (int i = 0; i < 8; i++) hex_disp[i] = glyph(bus.wdata[4*i +: 4]);
  end

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    disp_d  = disp_q;

    unique case (state_q)
      StIdle: ;
      StLoad: begin
        sign_d  = wdata_q[31];
        mag_d   = wdata_q[31] ? (~wdata_q + 32'd1) : wdata_q;
        bcd_d   = '0;
        iter_d  = '0;
        state_d = StShift;
      end
      StShift: begin
        bcd_d  = {bcd_adj[38:0], mag_q[31]};
        mag_d  = {mag_q[30:0], 1'b0};
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) state_d = StCommit;
      end
      StCommit: begin
        disp_d  = dec_disp;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new write always wins, including over a result about to commit.
    if (bus.seg_we) begin
      if (bus.dec_mode) begin
        wdata_d = bus.wdata;
        disp_d  = disp_q;
        state_d = StLoad;
      end else begin
        disp_d  = hex_disp;
        state_d = StIdle;
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_comb begin
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
      idx_d = idx_q;
    end
    seg_en_d  = ~(8'd1 << idx_q);
    seg_out_d = disp_q[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wdata_q   <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      disp_q    <= {8{8'hC0}};
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      seg_en_q  <= 8'hFF;
      seg_out_q <= 8'hFF;
    end else begin
      state_q   <= state_d;
      wdata_q   <= wdata_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      disp_q    <= disp_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seg_en_q  <= seg_en_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign seg_en   = seg_en_q;
  assign seg_out  = seg_out_q;
  assign bus.busy = busy_q;

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Seven-segment display controller at the device end of the CPU's segment write path. It accepts a 32-bit value each time the memory/IO stage asserts its segment write strobe, and shows it as 8 hex digits or as a signed decimal number. Decimal mode uses a sequential binary-to-BCD converter. The controller time-multiplexes the 8 digits of the board display.

## Interface
Parameters:
- SCAN_DIV, default 50000: clock cycles each digit stays enabled; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- seg_we  in  1  write strobe (SegCtrl from the memory/IO stage); one-cycle pulse per store.
- wdata  in  32  value to display; sampled when seg_we=1.
- dec_mode  in  1  sampled with seg_we; 1 = signed decimal, 0 = hex.
- seg_en  out  8  digit enables, active-low; bit 0 = rightmost digit.
- seg_out  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- busy  out  1  decimal conversion in progress.

## Operation
- Glyphs (dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E, '-' BF, blank FF.
- Display buffer: 8 glyph registers, updated atomically. Between updates, the previous contents stay on screen.
- Hex write: digit i shows wdata[4i+3:4i]. No leading-zero blanking.
- Decimal write FSM states:
  - IDLE --seg_we&dec_mode--> LOAD. LOAD latches sign = wdata[31] and mag = |wdata| as 32-bit unsigned (0x80000000 gives 2147483648). It also clears 10 BCD nibbles.
  - LOAD → SHIFT. SHIFT performs 32 double-dabble iterations, one per cycle: add 3 to each nibble ≥ 5, then shift left with the mag MSB entering.
  - SHIFT → COMMIT after 32 iterations. COMMIT formats the result, writes the buffer, and returns to IDLE.
- Decimal formatting:
  - Leading zeros are blanked. Value 0 shows '0' on digit 0 only.
  - For negatives, '-' goes on the digit immediately left of the most-significant digit.
  - Overflow when positive > 99_999_999 or negative magnitude > 9_999_999: all 8 digits show '-'.
- Last write wins:
  - seg_we during LOAD/SHIFT with dec_mode=1 restarts the conversion from LOAD with the new wdata.
  - seg_we with dec_mode=0 in any state aborts the conversion, commits the hex value, and returns to IDLE.
  - An aborted conversion never reaches the buffer.
- Scan:
  - A cycle counter runs 0..SCAN_DIV-1. The digit index advances on wrap, 0..7, then wraps to 0.
  - seg_en is all ones except bit[index]; seg_out is the buffer glyph for that index.
  - The scan runs continuously and independently of writes.

## Timing
- Reset (asynchronous, immediate):
  - seg_en=FF, seg_out=FF, busy=0, FSM=IDLE, counter=0, index=0.
  - Buffer = eight '0' glyphs (C0), i.e. hex 00000000.
- First edge after rst_n rises: seg_en=FE, seg_out=C0.
- seg_en and seg_out are registered: an index change appears on the edge after the counter wrap. Both change on the same edge; there is no blanking gap.
- Hex write sampled at edge E0: the buffer updates at E0. The change is visible on seg_out by E0+1, when that digit is selected.
- Decimal write sampled at edge E0:
  - busy=1 from E0; LOAD occupies one cycle, then 32 SHIFT cycles.
  - COMMIT writes the buffer at E0+34; busy=0 after E0+34.
  - Total latency: 34 cycles.
- Reset asserted mid-conversion: conversion discarded, buffer returns to all '0'.
- seg_we in the same cycle as COMMIT: the new write wins and the old result is not committed.

## Test plan
- Reset mid-scan and mid-conversion (SCAN_DIV=4) → seg_en=FF, seg_out=FF, busy=0 asynchronously. After release, the digits cycle FE, FD, … 7F, each for 4 cycles, all showing C0.
- Hex write 0x1234ABCD → digit0 A1, digit1 C6, digit2 83, digit3 88, digit4 99, digit5 B0, digit6 A4, digit7 F9.
- Decimal write 123 → busy high exactly 34 cycles. Then digit0 B0, digit1 A4, digit2 F9, digits 3–7 FF.
- Decimal writes:
  - −45 (0xFFFFFFD3) → digit0 92, digit1 99, digit2 BF, rest FF.
  - 0x80000000 → all BF.
  - 99_999_999 → all 90.
  - 100_000_000 → all BF.
- Decimal write 5, then decimal write 9 three cycles later → '5' is never displayed. digit0 shows 90 from 34 cycles after the second write.
- Decimal write 7, then hex write 0x0000000F during SHIFT → FSM returns to IDLE and busy drops. The buffer shows hex 0000000F (digit0 8E, others C0) and never shows '7'.
